// File: rtl/flow_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flow_seq_pkg: shared state encoding and mux-select constants for the     |
// | flow_sequencer control block.                                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package flow_seq_pkg;

    localparam int W = 16;

    typedef enum logic [3:0] {
        ST_IDLE           = 4'd0,
        ST_CALL_PUSH      = 4'd1,
        ST_RET_POP        = 4'd2,
        ST_RET_LOAD       = 4'd3,
        ST_RTI_POP_FLAGS  = 4'd4,
        ST_RTI_POP_PC     = 4'd5,
        ST_RTI_LOAD       = 4'd6,
        ST_INT_PUSH_PC    = 4'd7,
        ST_INT_PUSH_FLAGS = 4'd8,
        ST_INT_VECTOR     = 4'd9
    } seq_state_t;

    localparam logic [1:0] PC_SEL_NEXT = 2'b00;
    localparam logic [1:0] PC_SEL_CALL = 2'b01;
    localparam logic [1:0] PC_SEL_POP  = 2'b10;
    localparam logic [1:0] PC_SEL_VEC  = 2'b11;

    localparam logic STACK_SEL_PC    = 1'b0;
    localparam logic STACK_SEL_FLAGS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/flow_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flow_sequencer_if: decode-side strobes in, PC/F-D/stack controls out.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface flow_sequencer_if;

    logic       interrupt;
    logic       id_valid;
    logic       op_call;
    logic       op_ret;
    logic       op_rti;
    logic       stall_in;

    logic       pc_enable;
    logic       fd_enable;
    logic       flush;
    logic       push;
    logic       pop;
    logic       stack_sel;
    logic [1:0] pc_sel;
    logic       flags_restore;
    logic       int_ack;
    logic       busy;

    modport master (
        output interrupt, id_valid, op_call, op_ret, op_rti, stall_in,
        input  pc_enable, fd_enable, flush, push, pop, stack_sel, pc_sel,
               flags_restore, int_ack, busy
    );

    modport slave (
        input  interrupt, id_valid, op_call, op_ret, op_rti, stall_in,
        output pc_enable, fd_enable, flush, push, pop, stack_sel, pc_sel,
               flags_restore, int_ack, busy
    );

endinterface
`default_nettype wire

// File: rtl/flow_sequencer_int_edge_latch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | int_edge_latch: rising-edge detector with a single-deep pending bit;     |
// | a new edge wins over a simultaneous clear.                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module int_edge_latch (
    input  wire  clk,
    input  wire  rst,
    input  wire  interrupt,
    input  wire  clr,
    output logic pending
);

    logic r_int_d;
    logic w_rise;

    assign w_rise = interrupt & ~r_int_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_d <= 1'b0;
            pending <= 1'b0;
        end else begin
            r_int_d <= interrupt;
            if (w_rise)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flow_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flow_sequencer: multi-cycle CALL/RET/RTI/interrupt-entry sequencer.      |
// | Define FLOW_SEQ_FLAGS_SAVE_EN to push/pop the flags word as well.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flow_sequencer
    import flow_seq_pkg::*;
(
    input  wire             clk,
    input  wire             rst,
    flow_sequencer_if.slave bus
);

`ifdef FLOW_SEQ_FLAGS_SAVE_EN
    localparam seq_state_t C_RTI_FIRST    = ST_RTI_POP_FLAGS;
    localparam seq_state_t C_INT_AFTER_PC = ST_INT_PUSH_FLAGS;
`else
    localparam seq_state_t C_RTI_FIRST    = ST_RTI_POP_PC;
    localparam seq_state_t C_INT_AFTER_PC = ST_INT_VECTOR;
`endif

    seq_state_t r_state;
    seq_state_t w_next;
    logic       r_int_mask;
    logic       w_pending;
    logic       w_int_clr;

    logic       w_pc_enable;
    logic       w_fd_enable;
    logic       w_flush;
    logic       w_push;
    logic       w_pop;
    logic       w_stack_sel;
    logic [1:0] w_pc_sel;
    logic       w_flags_restore;
    logic       w_int_ack;

    // Pending is only consumed when INT_VECTOR actually retires.
    assign w_int_clr = (r_state == ST_INT_VECTOR) && !bus.stall_in;

    int_edge_latch u_int_edge_latch (
        .clk       (clk),
        .rst       (rst),
        .interrupt (bus.interrupt),
        .clr       (w_int_clr),
        .pending   (w_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_int_mask <= 1'b0;
        else if (!bus.stall_in) begin
            if (r_state == ST_INT_VECTOR)
                r_int_mask <= 1'b1;
            else if (r_state == ST_RTI_LOAD)
                r_int_mask <= 1'b0;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_pc_enable     = 1'b0;
        w_fd_enable     = 1'b0;
        w_flush         = 1'b1;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_stack_sel     = STACK_SEL_PC;
        w_pc_sel        = PC_SEL_NEXT;
        w_flags_restore = 1'b0;
        w_int_ack       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_pc_enable = 1'b1;
                w_fd_enable = 1'b1;
                w_flush     = 1'b0;
                if (bus.id_valid && bus.op_rti)
                    w_next = C_RTI_FIRST;
                else if (bus.id_valid && bus.op_ret)
                    w_next = ST_RET_POP;
                else if (bus.id_valid && bus.op_call)
                    w_next = ST_CALL_PUSH;
                else if (w_pending && !r_int_mask)
                    w_next = ST_INT_PUSH_PC;
            end
            ST_CALL_PUSH: begin
                w_push      = 1'b1;
                w_pc_sel    = PC_SEL_CALL;
                w_pc_enable = 1'b1;
                w_next      = ST_IDLE;
            end
            ST_RET_POP: begin
                w_pop  = 1'b1;
                w_next = ST_RET_LOAD;
            end
            ST_RET_LOAD: begin
                w_pc_sel    = PC_SEL_POP;
                w_pc_enable = 1'b1;
                w_next      = ST_IDLE;
            end
`ifdef FLOW_SEQ_FLAGS_SAVE_EN
            ST_RTI_POP_FLAGS: begin
                w_pop           = 1'b1;
                w_stack_sel     = STACK_SEL_FLAGS;
                w_flags_restore = 1'b1;
                w_next          = ST_RTI_POP_PC;
            end
            ST_INT_PUSH_FLAGS: begin
                w_push      = 1'b1;
                w_stack_sel = STACK_SEL_FLAGS;
                w_next      = ST_INT_VECTOR;
            end
`endif
            ST_RTI_POP_PC: begin
                w_pop  = 1'b1;
                w_next = ST_RTI_LOAD;
            end
            ST_RTI_LOAD: begin
                w_pc_sel    = PC_SEL_POP;
                w_pc_enable = 1'b1;
                w_next      = ST_IDLE;
            end
            ST_INT_PUSH_PC: begin
                w_push = 1'b1;
                w_next = C_INT_AFTER_PC;
            end
            ST_INT_VECTOR: begin
                w_pc_sel    = PC_SEL_VEC;
                w_pc_enable = 1'b1;
                w_int_ack   = 1'b1;
                w_next      = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // A stall freezes the sequence and suppresses every one-shot request.
        if (bus.stall_in) begin
            w_next          = r_state;
            w_pc_enable     = 1'b0;
            w_push          = 1'b0;
            w_pop           = 1'b0;
            w_flags_restore = 1'b0;
            w_int_ack       = 1'b0;
        end
    end

    assign bus.pc_enable     = w_pc_enable;
    assign bus.fd_enable     = w_fd_enable;
    assign bus.flush         = w_flush;
    assign bus.push          = w_push;
    assign bus.pop           = w_pop;
    assign bus.stack_sel     = w_stack_sel;
    assign bus.pc_sel        = w_pc_sel;
    assign bus.flags_restore = w_flags_restore;
    assign bus.int_ack       = w_int_ack;
    assign bus.busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
